rx_session_ctrl: RTL

RX_SESSION_CTRL -- requirements
Module: rx_session_ctrl

---
 rtl/swipt_pkg.sv | 28 ++
 rtl/rx_session_ctrl_if.sv | 27 ++
 rtl/rx_session_ctrl_cycle_timer.sv | 28 ++
 rtl/rx_session_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/swipt_pkg.sv
// Shared SWIPT receive definitions: session states, response status codes and
// the program value that enables reception.
package swipt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LISTEN = 3'd1,
      ST_CHECK  = 3'd2,
      ST_GAP    = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_CSUM    = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT = 2'b10;
   localparam logic [1:0] RSP_ABORT   = 2'b11;

   localparam logic [1:0] PROGRAM_RX = 2'b11;

   localparam int TIMER_W = 24;
   localparam int RETRY_W = 8;

   typedef struct packed {
      state_t              state;
      logic [RETRY_W-1:0]  retry_cnt;
   } dbg_t;

endpackage

// File: rtl/rx_session_ctrl_if.sv
// Host-side request/response channels of the receive session controller.
// Both channels are valid/ready: a transfer happens on a clock edge where valid
// and ready are both high; once raised, valid and its payload stay stable until
// that transfer.
interface rx_session_ctrl_if;

   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_mode;
   logic [1:0] req_type;

   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [1:0] rsp_status;

   modport master (
      output req_valid, req_mode, req_type, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_status
   );

   modport slave (
      input  req_valid, req_mode, req_type, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_status
   );

endinterface

// File: rtl/rx_session_ctrl_cycle_timer.sv
// Up-counting cycle timer shared by the listen timeout and the retry gap;
// tc flags the cycle in which the count equals the terminal value.
module cycle_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == term);

endmodule

// File: rtl/rx_session_ctrl.sv
// Receive session controller: one host request drives listen windows, checksum
// evaluation, optional retries (RX_SESSION_RETRY_EN) and a single response.
module rx_session_ctrl
   import swipt_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYC = 24'd800000,
   parameter logic [15:0] GAP_CYC     = 16'd1000,
   parameter int          MAX_RETRY   = 2
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                swiptAlive,
   input  logic [1:0]          prog,
   rx_session_ctrl_if.slave    host,
   input  logic                dataInReady,
   input  logic [7:0]          dataIn,
   input  logic                checkSumBit,
   output logic                readDataIn,
   output logic [1:0]          mode,
   output logic [1:0]          rx_type,
   output logic                busy,
   output dbg_t                dbg
);

`ifdef RX_SESSION_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif
   localparam logic [RETRY_W-1:0] MAX_RETRY_L = RETRY_W'(MAX_RETRY);

   state_t             state, state_nx;
   logic [1:0]         mode_nx, type_nx;
   logic [7:0]         cap_data, cap_data_nx;
   logic               cap_csum, cap_csum_nx;
   logic [RETRY_W-1:0] retry_cnt, retry_nx;
   logic [1:0]         status_q, status_nx;
   logic [7:0]         data_q, data_nx;
   logic               rsp_valid_q, read_q, busy_q;
   logic               tmr_load, tmr_en, tmr_tc;
   logic [TIMER_W-1:0] tmr_term;
   logic               link_ok, retry_ok;

   assign link_ok  = swiptAlive && (prog == PROGRAM_RX);
   assign retry_ok = RETRY_ON && (retry_cnt < MAX_RETRY_L);

   assign tmr_term = (state == ST_GAP) ? {8'd0, GAP_CYC - 16'd1} : TIMEOUT_CYC - 24'd1;

   cycle_timer #(.W(TIMER_W)) u_timer (
      .clk    (clk),
      .nrst   (nrst),
      .load   (tmr_load),
      .enable (tmr_en),
      .term   (tmr_term),
      .tc     (tmr_tc)
   );

   always_comb begin
      state_nx    = state;
      mode_nx     = mode;
      type_nx     = rx_type;
      cap_data_nx = cap_data;
      cap_csum_nx = cap_csum;
      retry_nx    = retry_cnt;
      status_nx   = status_q;
      data_nx     = data_q;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (host.req_valid && host.req_ready) begin
               state_nx = ST_LISTEN;
               mode_nx  = host.req_mode;
               type_nx  = host.req_type;
               retry_nx = '0;
               tmr_load = 1'b1;
            end
         end
         ST_LISTEN: begin
            tmr_en = 1'b1;
            // Abort beats data, and data beats a timeout landing on the same cycle.
            if (!link_ok) begin
               state_nx  = ST_RESP;
               status_nx = RSP_ABORT;
               data_nx   = 8'h00;
            end else if (dataInReady) begin
               state_nx    = ST_CHECK;
               cap_data_nx = dataIn;
               cap_csum_nx = checkSumBit;
            end else if (tmr_tc) begin
               if (retry_ok) begin
                  state_nx = ST_GAP;
                  tmr_load = 1'b1;
               end else begin
                  state_nx  = ST_RESP;
                  status_nx = RSP_TIMEOUT;
                  data_nx   = 8'h00;
               end
            end
         end
         ST_CHECK: begin
            if (!link_ok) begin
               state_nx  = ST_RESP;
               status_nx = RSP_ABORT;
               data_nx   = 8'h00;
            end else if (!cap_csum) begin
               state_nx  = ST_RESP;
               status_nx = RSP_OK;
               data_nx   = cap_data;
            end else if (retry_ok) begin
               state_nx = ST_GAP;
               tmr_load = 1'b1;
            end else begin
               state_nx  = ST_RESP;
               status_nx = RSP_CSUM;
               data_nx   = cap_data;
            end
         end
         ST_GAP: begin
            tmr_en = 1'b1;
            if (!link_ok) begin
               state_nx  = ST_RESP;
               status_nx = RSP_ABORT;
               data_nx   = 8'h00;
            end else if (tmr_tc) begin
               state_nx = ST_LISTEN;
               retry_nx = retry_cnt + 1'b1;
               tmr_load = 1'b1;
            end
         end
         ST_RESP: begin
            if (host.rsp_ready) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state       <= ST_IDLE;
         mode        <= 2'b00;
         rx_type     <= 2'b00;
         cap_data    <= 8'h00;
         cap_csum    <= 1'b0;
         retry_cnt   <= '0;
         status_q    <= RSP_OK;
         data_q      <= 8'h00;
         rsp_valid_q <= 1'b0;
         read_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         mode        <= mode_nx;
         rx_type     <= type_nx;
         cap_data    <= cap_data_nx;
         cap_csum    <= cap_csum_nx;
         retry_cnt   <= retry_nx;
         status_q    <= status_nx;
         data_q      <= data_nx;
         rsp_valid_q <= (state_nx == ST_RESP);
         read_q      <= (state_nx == ST_LISTEN);
         busy_q      <= (state_nx != ST_IDLE);
      end
   end

   assign host.req_ready  = (state == ST_IDLE) && swiptAlive && (prog == PROGRAM_RX) && nrst;
   assign host.rsp_valid  = rsp_valid_q;
   assign host.rsp_status = status_q;
   assign host.rsp_data   = data_q;
   assign readDataIn      = read_q;
   assign busy            = busy_q;
   assign dbg             = {state, retry_cnt};

endmodule
